// File: rtl/posit_add_issue.sv
// posit_add_issue: operand-pair FIFO with credit-gated issue into a posit adder.
// Optional sticky NaR-operand flag enabled by POSIT_ADD_ISSUE_NAR_FLAG_EN.
module posit_add_issue #(
    parameter int N       = 36,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [N-1:0]               s_in1,
    input  logic [N-1:0]               s_in2,
    output logic [N-1:0]               add_in1,
    output logic [N-1:0]               add_in2,
    output logic                       add_start,
    input  logic                       credit_ret,
    output logic [$clog2(CREDITS):0]   credit_cnt,
    output logic                       credit_err,
    output logic                       nar_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDITS) + 1;

    logic [2*N-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [2*N-1:0] head;
    logic           push, issue, credit_full;

    assign s_ready     = count < (AW+1)'(DEPTH);
    assign push        = s_valid && s_ready;
    assign issue       = (count != '0) && (credit_cnt != '0);
    assign head        = mem[rd_ptr];
    assign credit_full = credit_cnt == CW'(CREDITS);

    // Storage is left unreset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {s_in1, s_in2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            add_start  <= 1'b0;
            add_in1    <= '0;
            add_in2    <= '0;
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (issue)
                rd_ptr <= rd_ptr + AW'(1);
            count     <= count + (AW+1)'(push) - (AW+1)'(issue);
            add_start <= issue;
            if (issue)
                {add_in1, add_in2} <= head;
            if (issue && !credit_ret)
                credit_cnt <= credit_cnt - CW'(1);
            else if (credit_ret && !issue) begin
                if (credit_full)
                    credit_err <= 1'b1;
                else
                    credit_cnt <= credit_cnt + CW'(1);
            end
        end
    end

`ifdef POSIT_ADD_ISSUE_NAR_FLAG_EN
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nar_flag <= 1'b0;
        else if (issue && (head[2*N-1:N] == NAR || head[N-1:0] == NAR))
            nar_flag <= 1'b1;
    end
`else
    assign nar_flag = 1'b0;
`endif

endmodule

// File: tb/tb_posit_add_issue.sv
// tb_posit_add_issue: table-driven cycle vectors plus directed reset, overflow,
// NaR and simultaneous push/issue/credit sequences.
module tb_posit_add_issue;
    localparam int N = 36;
`ifdef POSIT_ADD_ISSUE_NAR_FLAG_EN
    localparam logic NAR_EN = 1'b1;
`else
    localparam logic NAR_EN = 1'b0;
`endif
    localparam logic [N-1:0] A   = 36'h400000000;
    localparam logic [N-1:0] NAR = 36'h800000000;

    logic         clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, credit_ret = 1'b0;
    logic [N-1:0] s_in1 = '0, s_in2 = '0;
    logic         s_ready, add_start, credit_err, nar_flag;
    logic [N-1:0] add_in1, add_in2;
    logic [3:0]   credit_cnt;

    int passed = 0, total = 0;

    posit_add_issue #(.N(N), .DEPTH(4), .CREDITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_in1(s_in1), .s_in2(s_in2), .add_in1(add_in1), .add_in2(add_in2),
        .add_start(add_start), .credit_ret(credit_ret), .credit_cnt(credit_cnt),
        .credit_err(credit_err), .nar_flag(nar_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [N-1:0] a, b;
        logic         ret;
        logic         rdy, st;
        logic [N-1:0] o1, o2;
        logic [3:0]   cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic expect_all(input string tag, input logic rdy, input logic st,
                              input logic [N-1:0] o1, input logic [N-1:0] o2,
                              input logic [3:0] cnt, input logic err, input logic nar);
        chk({tag, ".s_ready"}, s_ready, rdy);
        chk({tag, ".add_start"}, add_start, st);
        chk({tag, ".add_in1"}, add_in1, o1);
        chk({tag, ".add_in2"}, add_in2, o2);
        chk({tag, ".credit_cnt"}, credit_cnt, cnt);
        chk({tag, ".credit_err"}, credit_err, err);
        chk({tag, ".nar_flag"}, nar_flag, nar);
    endtask

    // Drive inputs, take one rising edge, leave time 1 past the edge for sampling.
    task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic r);
        s_valid = v; s_in1 = a; s_in2 = b; credit_ret = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single pair, then credit return to refill to 8.
        tbl.push_back('{1'b1, A, A, 1'b0, 1'b1, 1'b0, '0, '0, 4'd8});
        tbl.push_back('{1'b0, '0, '0, 1'b0, 1'b1, 1'b1, A, A, 4'd7});
        tbl.push_back('{1'b0, '0, '0, 1'b0, 1'b1, 1'b0, A, A, 4'd7});
        tbl.push_back('{1'b0, '0, '0, 1'b1, 1'b1, 1'b0, A, A, 4'd8});
        // 12 back-to-back pushes: edge k issues pair k-1 while credits last.
        for (int k = 1; k <= 12; k++) begin
            if (k == 1)
                tbl.push_back('{1'b1, N'(k), N'(k+100), 1'b0, 1'b1, 1'b0, A, A, 4'd8});
            else if (k <= 9)
                tbl.push_back('{1'b1, N'(k), N'(k+100), 1'b0, 1'b1, 1'b1, N'(k-1), N'(k+99), 4'(9-k)});
            else
                tbl.push_back('{1'b1, N'(k), N'(k+100), 1'b0, k < 12, 1'b0, N'(8), N'(108), 4'd0});
        end
        tbl.push_back('{1'b0, '0, '0, 1'b0, 1'b0, 1'b0, N'(8), N'(108), 4'd0});
        tbl.push_back('{1'b0, '0, '0, 1'b1, 1'b0, 1'b0, N'(8), N'(108), 4'd1});
        tbl.push_back('{1'b0, '0, '0, 1'b0, 1'b1, 1'b1, N'(9), N'(109), 4'd0});

        #12;
        expect_all("reset", 1'b1, 1'b0, '0, '0, 4'd8, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", s_ready, 1'b1);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].ret);
            expect_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].st, tbl[i].o1, tbl[i].o2,
                       tbl[i].cnt, 1'b0, 1'b0);
        end

        // Three pairs queued and add_start high: async reset clears everything at once.
        #2 rst_n = 1'b0;
        #1 expect_all("rst_mid", 1'b1, 1'b0, '0, '0, 4'd8, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b0);
            expect_all($sformatf("no_stale%0d", i), 1'b1, 1'b0, '0, '0, 4'd8, 1'b0, 1'b0);
        end

        // Credit overflow is sticky.
        step(1'b0, '0, '0, 1'b1);
        expect_all("ovf", 1'b1, 1'b0, '0, '0, 4'd8, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        expect_all("ovf_hold", 1'b1, 1'b0, '0, '0, 4'd8, 1'b1, 1'b0);

        // NaR operand.
        step(1'b1, N'(1), NAR, 1'b0);
        expect_all("nar_push", 1'b1, 1'b0, '0, '0, 4'd8, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        expect_all("nar_issue", 1'b1, 1'b1, N'(1), NAR, 4'd7, 1'b1, NAR_EN);
        step(1'b0, '0, '0, 1'b0);
        expect_all("nar_hold", 1'b1, 1'b0, N'(1), NAR, 4'd7, 1'b1, NAR_EN);

        rst_n = 1'b0;
        #1 expect_all("rst_pulse", 1'b1, 1'b0, '0, '0, 4'd8, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        // Reach occupancy 1 / credit 1, then push+issue+credit_ret on one edge.
        for (int k = 1; k <= 8; k++)
            step(1'b1, N'(k), N'(k), 1'b0);
        expect_all("sim_pre", 1'b1, 1'b1, N'(7), N'(7), 4'd1, 1'b0, 1'b0);
        step(1'b1, N'(9), N'(9), 1'b1);
        expect_all("sim_edge", 1'b1, 1'b1, N'(8), N'(8), 4'd1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        expect_all("sim_next", 1'b1, 1'b1, N'(9), N'(9), 4'd0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        expect_all("sim_idle", 1'b1, 1'b0, N'(9), N'(9), 4'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/posit_add_issue.md
POSIT_ADD_ISSUE -- requirements
Module: posit_add_issue

Interface
REQ-001 The block SHALL expose parameter N, default 36, meaning posit word width, matching the downstream adder.
REQ-002 The block SHALL expose parameter DEPTH, default 4, meaning operand-pair FIFO entries (power of 2, at least 2).
REQ-003 The block SHALL expose parameter CREDITS, default 8, meaning downstream result-buffer slots (at least 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port s_valid, input, 1 bit: upstream operand pair valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit: FIFO can accept a pair.
REQ-008 The block SHALL have ports s_in1 and s_in2, input, N bits each: operand posits.
REQ-009 The block SHALL have ports add_in1 and add_in2, output, N bits each, registered: operands to the adder.
REQ-010 The block SHALL have port add_start, output, 1 bit, registered: adder start pulse.
REQ-011 The block SHALL have port credit_ret, input, 1 bit: downstream freed one result slot this cycle.
REQ-012 The block SHALL have port credit_cnt, output, log2(CREDITS)+1 bits: available credits.
REQ-013 The block SHALL have port credit_err, output, 1 bit: sticky flag for credit overflow.
REQ-014 The block SHALL have port nar_flag, output, 1 bit: sticky NaR-operand flag (macro-dependent).

Function
REQ-015 s_ready SHALL be 1 exactly when the FIFO occupancy is less than DEPTH, derived from registered state only, with no combinational path from s_valid.
REQ-016 A push SHALL occur on any edge with s_valid=1 and s_ready=1, writing {s_in1, s_in2} at the write pointer; pointers SHALL wrap modulo DEPTH.
REQ-017 An issue SHALL occur on any edge where occupancy>0 and credit_cnt>0; on that edge the head pair loads add_in1/add_in2, add_start<=1, and the entry pops.
REQ-018 On edges without an issue, add_start SHALL be 0 and add_in1/add_in2 SHALL hold their previous values.
REQ-019 Latency: a pair pushed at edge t SHALL be issued at the earliest at edge t+1, so add_start is high in the cycle after t+1.
REQ-020 A push and an issue on the same edge SHALL both take effect, leaving occupancy unchanged, including when occupancy is 1.
REQ-021 Issue order SHALL equal push order; the block supports at most one issue per cycle, matching the adder's one-operation-per-cycle rate.
REQ-022 credit_cnt SHALL decrement by 1 on each issue and increment by 1 on each credit_ret=1; when both occur on the same edge, it SHALL be unchanged.
REQ-023 If credit_ret=1 arrives without a same-edge issue while credit_cnt=CREDITS, credit_cnt SHALL stay at CREDITS and credit_err SHALL set and remain 1 until reset.
REQ-024 With credit_cnt=0, no issue SHALL occur; the FIFO SHALL keep filling until full, then s_ready=0.

Reset
REQ-025 Asserting rst_n=0 SHALL asynchronously clear the pointers and occupancy, set credit_cnt to CREDITS, and clear add_start, add_in1, add_in2, credit_err and nar_flag to 0.
REQ-026 Reset mid-operation SHALL discard all queued pairs; FIFO RAM contents need not be cleared.
REQ-027 After reset, s_ready SHALL be 1 in the first cycle.

Configuration
REQ-028 With POSIT_ADD_ISSUE_NAR_FLAG_EN defined, nar_flag SHALL set on an issue edge whose head pair has either operand equal to NaR (MSB=1, remaining bits 0), and SHALL stay set until reset.
REQ-029 Without POSIT_ADD_ISSUE_NAR_FLAG_EN, nar_flag SHALL be tied to 0 and no NaR detection logic SHALL be synthesised.

Verification
REQ-030 Single pair: after reset, push 0x400000000/0x400000000 at edge 1 -> add_start high for exactly one cycle after edge 2, with add_in1 and add_in2 both 0x400000000 and credit_cnt=7.
REQ-031 Credit starvation: CREDITS=8 with no credit_ret, push 12 pairs back-to-back -> exactly 8 issues, occupancy reaches 4, s_ready=0, credit_cnt=0; one credit_ret then gives exactly one issue on the next edge.
REQ-032 Simultaneous events: occupancy 1 and credit_cnt 1, with push, issue and credit_ret on the same edge -> occupancy 1, credit_cnt 1, and the next pair issues on the following edge.
REQ-033 Overflow: credit_ret=1 with credit_cnt=8 and no issue -> credit_cnt stays 8 and credit_err=1 until rst_n is pulsed.
REQ-034 Reset mid-stream: assert rst_n=0 with 3 entries queued and add_start high -> all outputs clear immediately, and no stale pair issues after release.
REQ-035 Macro: with POSIT_ADD_ISSUE_NAR_FLAG_EN defined, issue s_in2=0x800000000 -> nar_flag=1 from the issue edge onward; without the macro, nar_flag stays 0.
